// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC_32I control path: opcodes,
// FSM states, ALU operation codes and datapath mux select values.
package rv_ctrl_pkg;

   localparam int OPC_W = 7;
   localparam int ST_W  = 4;

   localparam logic [OPC_W-1:0] OP_LW   = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_SW   = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_R    = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_IALU = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_B    = 7'b1100011;
   localparam logic [OPC_W-1:0] OP_JAL  = 7'b1101111;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;

   typedef enum logic [ST_W-1:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_control_fsm_alu_dec.sv
// ALU decoder: turns the FSM's coarse ALUOp plus the instruction's funct
// fields into the concrete ALUControl code.
module alu_dec
   import rv_ctrl_pkg::*;
(
   input  logic       i_op5,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   input  logic [1:0] i_aluOp,
   output logic [2:0] o_aluControl
);

   // Only R-type (op[5]=1) distinguishes sub; addi with imm[10]=1 stays add.
   always_comb begin
      o_aluControl = ALU_ADD;
      case (i_aluOp)
         ALUOP_ADD: o_aluControl = ALU_ADD;
         ALUOP_SUB: o_aluControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (i_funct3)
               3'b000:  o_aluControl = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  o_aluControl = ALU_SLT;
               3'b110:  o_aluControl = ALU_OR;
               3'b111:  o_aluControl = ALU_AND;
               default: o_aluControl = ALU_ADD;
            endcase
         end
         default: o_aluControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the RISC_32I datapath with a shared
// instruction/data memory and a req/ready memory handshake.
module mc_control_fsm
   import rv_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OPC_W-1:0] op,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic             Zero,
   input  logic             Sign_Flag,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             MemWrite,
   output logic             AdrSrc,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             RegWrite,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ImmSrc,
   output logic [2:0]       ALUControl,
   output logic             illegal_instr,
   output logic             instr_retired
);

   state_t     r_state;
   state_t     w_nextState;
   aluop_t     w_aluOp;
   logic [2:0] w_aluControl;
   logic       w_branchTaken;
   logic       w_memReq, w_memWrite, w_adrSrc, w_irWrite, w_pcWrite, w_regWrite;
   logic [1:0] w_aluSrcA, w_aluSrcB, w_resultSrc, w_immSrc;
   logic       w_illegal, w_retired;
   logic       w_unused_funct7;

   // Only funct7[5] matters to this core's ALU decode.
   assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

   assign w_branchTaken = ((funct3 == F3_BEQ) &  Zero)
                        | ((funct3 == F3_BNE) & ~Zero)
                        | ((funct3 == F3_BLT) &  Sign_Flag);

   // State register; reset always returns to FETCH, abandoning any access.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and Moore outputs, with handshake/branch gating where needed.
   always_comb begin
      w_nextState = r_state;
      w_memReq    = 1'b0;
      w_memWrite  = 1'b0;
      w_adrSrc    = 1'b0;
      w_irWrite   = 1'b0;
      w_pcWrite   = 1'b0;
      w_regWrite  = 1'b0;
      w_aluSrcA   = SRCA_PC;
      w_aluSrcB   = SRCB_RD2;
      w_resultSrc = RES_ALUOUT;
      w_immSrc    = IMM_I;
      w_aluOp     = ALUOP_ADD;
      w_illegal   = 1'b0;
      w_retired   = 1'b0;
      case (r_state)
         FETCH: begin
            w_memReq    = 1'b1;
            w_aluSrcB   = SRCB_FOUR;
            w_resultSrc = RES_ALURESULT;
            if (mem_ready) begin
               w_irWrite   = 1'b1;
               w_pcWrite   = 1'b1;
               w_nextState = DECODE;
            end
         end
         DECODE: begin
            w_aluSrcA = SRCA_OLDPC;
            w_aluSrcB = SRCB_IMM;
            w_immSrc  = IMM_B;
            case (op)
               OP_LW, OP_SW: w_nextState = MEMADR;
               OP_R:         w_nextState = EXECR;
               OP_IALU:      w_nextState = EXECI;
               OP_B:         w_nextState = BRANCH;
               OP_JAL:       w_nextState = JAL;
               default: begin
                  w_illegal   = 1'b1;
                  w_nextState = FETCH;
               end
            endcase
         end
         MEMADR: begin
            w_aluSrcA   = SRCA_RD1;
            w_aluSrcB   = SRCB_IMM;
            w_immSrc    = (op == OP_SW) ? IMM_S : IMM_I;
            w_nextState = (op == OP_LW) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            w_memReq = 1'b1;
            w_adrSrc = 1'b1;
            if (mem_ready) w_nextState = MEMWB;
         end
         MEMWB: begin
            w_resultSrc = RES_DATA;
            w_regWrite  = 1'b1;
            w_retired   = 1'b1;
            w_nextState = FETCH;
         end
         MEMWRITE: begin
            w_memReq   = 1'b1;
            w_memWrite = 1'b1;
            w_adrSrc   = 1'b1;
            if (mem_ready) begin
               w_retired   = 1'b1;
               w_nextState = FETCH;
            end
         end
         EXECR: begin
            w_aluSrcA   = SRCA_RD1;
            w_aluSrcB   = SRCB_RD2;
            w_aluOp     = ALUOP_FUNCT;
            w_nextState = ALUWB;
         end
         EXECI: begin
            w_aluSrcA   = SRCA_RD1;
            w_aluSrcB   = SRCB_IMM;
            w_immSrc    = IMM_I;
            w_aluOp     = ALUOP_FUNCT;
            w_nextState = ALUWB;
         end
         ALUWB: begin
            w_resultSrc = RES_ALUOUT;
            w_regWrite  = 1'b1;
            w_retired   = 1'b1;
            w_nextState = FETCH;
         end
         BRANCH: begin
            w_aluSrcA   = SRCA_RD1;
            w_aluSrcB   = SRCB_RD2;
            w_aluOp     = ALUOP_SUB;
            w_resultSrc = RES_ALUOUT;
            w_pcWrite   = w_branchTaken;
            w_retired   = 1'b1;
            w_nextState = FETCH;
         end
         JAL: begin
            w_aluSrcA   = SRCA_OLDPC;
            w_aluSrcB   = SRCB_FOUR;
            w_resultSrc = RES_ALUOUT;
            w_pcWrite   = 1'b1;
            w_nextState = ALUWB;
         end
         default: w_nextState = FETCH;
      endcase
   end

   alu_dec u_aluDec (
      .i_op5        (op[5]),
      .i_funct3     (funct3),
      .i_funct7b5   (funct7[5]),
      .i_aluOp      (w_aluOp),
      .o_aluControl (w_aluControl)
   );

   // Reset forces every control output low immediately, not at the next edge.
   assign mem_req       = rst_n & w_memReq;
   assign MemWrite      = rst_n & w_memWrite;
   assign AdrSrc        = rst_n & w_adrSrc;
   assign IRWrite       = rst_n & w_irWrite;
   assign PCWrite       = rst_n & w_pcWrite;
   assign RegWrite      = rst_n & w_regWrite;
   assign ALUSrcA       = rst_n ? w_aluSrcA    : 2'b00;
   assign ALUSrcB       = rst_n ? w_aluSrcB    : 2'b00;
   assign ResultSrc     = rst_n ? w_resultSrc  : 2'b00;
   assign ImmSrc        = rst_n ? w_immSrc     : 2'b00;
   assign ALUControl    = rst_n ? w_aluControl : 3'b000;
   assign illegal_instr = rst_n & w_illegal;
   assign instr_retired = rst_n & w_retired;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class cycle by
// cycle and compares the whole control-output bundle against hand values.
module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       Zero, Sign_Flag, mem_ready;
   logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic [2:0] ALUControl;
   logic       illegal_instr, instr_retired;

   int compared   = 0;
   int mismatched = 0;

   logic [18:0] obs;
   logic [18:0] F1, F0, DEC, DILL, WB, MALW, MASW, MR, MWB, MW0, MW1, JALV;

   always #5 clk = ~clk;

   mc_control_fsm dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .op            (op),
      .funct3        (funct3),
      .funct7        (funct7),
      .Zero          (Zero),
      .Sign_Flag     (Sign_Flag),
      .mem_ready     (mem_ready),
      .mem_req       (mem_req),
      .MemWrite      (MemWrite),
      .AdrSrc        (AdrSrc),
      .IRWrite       (IRWrite),
      .PCWrite       (PCWrite),
      .RegWrite      (RegWrite),
      .ALUSrcA       (ALUSrcA),
      .ALUSrcB       (ALUSrcB),
      .ResultSrc     (ResultSrc),
      .ImmSrc        (ImmSrc),
      .ALUControl    (ALUControl),
      .illegal_instr (illegal_instr),
      .instr_retired (instr_retired)
   );

   assign obs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                 ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl,
                 illegal_instr, instr_retired};

   // Packs expected outputs in the same order as obs.
   function automatic logic [18:0] pk(input logic req, input logic we, input logic adr,
                                      input logic irw, input logic pcw, input logic rw,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] rs, input logic [1:0] imm,
                                      input logic [2:0] alu, input logic ill, input logic ret);
      return {req, we, adr, irw, pcw, rw, a, b, rs, imm, alu, ill, ret};
   endfunction

   function automatic logic [18:0] execR(input logic [2:0] alu);
      return pk(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, alu, 0,0);
   endfunction

   function automatic logic [18:0] execI(input logic [2:0] alu);
      return pk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, alu, 0,0);
   endfunction

   function automatic logic [18:0] br(input logic pcw);
      return pk(0,0,0,0,pcw,0, 2'b10,2'b00,2'b00,2'b00, 3'b001, 0,1);
   endfunction

   task automatic applyStimulus(input logic [6:0] opv, input logic [2:0] f3,
                                input logic [6:0] f7, input logic z, input logic s,
                                input logic rdy);
      op        = opv;
      funct3    = f3;
      funct7    = f7;
      Zero      = z;
      Sign_Flag = s;
      mem_ready = rdy;
   endtask

   task automatic compare(input string tag, input logic [18:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
      end
   endtask

   // Checks mid-cycle, then advances to just after the next rising edge.
   task automatic checkOutput(input string tag, input logic [18:0] exp);
      @(negedge clk);
      compare(tag, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      F1   = pk(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0,0);
      F0   = pk(1,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0,0);
      DEC  = pk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b10, 3'b000, 0,0);
      DILL = pk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b10, 3'b000, 1,0);
      WB   = pk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,1);
      MALW = pk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 3'b000, 0,0);
      MASW = pk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b01, 3'b000, 0,0);
      MR   = pk(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,0);
      MWB  = pk(0,0,0,0,0,1, 2'b00,2'b00,2'b01,2'b00, 3'b000, 0,1);
      MW0  = pk(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,0);
      MW1  = pk(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,1);
      JALV = pk(0,0,0,0,1,0, 2'b01,2'b10,2'b00,2'b00, 3'b000, 0,0);

      $display("[TB] reset and add");
      rst_n = 1'b0;
      applyStimulus(7'b0000000, 3'b000, 7'b0000000, 0, 0, 1);
      repeat (3) checkOutput("reset_hold", 19'h0);
      rst_n = 1'b1;
      applyStimulus(7'b0110011, 3'b000, 7'b0000000, 0, 0, 1);
      checkOutput("add_fetch", F1);
      checkOutput("add_decode", DEC);
      checkOutput("add_execr", execR(3'b000));
      checkOutput("add_aluwb", WB);

      $display("[TB] lw with memory waits");
      applyStimulus(7'b0000011, 3'b010, 7'b0000000, 0, 0, 0);
      checkOutput("lw_fetch_wait1", F0);
      checkOutput("lw_fetch_wait2", F0);
      mem_ready = 1'b1;
      checkOutput("lw_fetch", F1);
      checkOutput("lw_decode", DEC);
      checkOutput("lw_memadr", MALW);
      mem_ready = 1'b0;
      repeat (3) checkOutput("lw_memread_wait", MR);
      mem_ready = 1'b1;
      checkOutput("lw_memread", MR);
      checkOutput("lw_memwb", MWB);

      $display("[TB] branches");
      applyStimulus(7'b1100011, 3'b001, 7'b0000000, 0, 0, 1);
      checkOutput("bne_fetch", F1);
      checkOutput("bne_decode", DEC);
      checkOutput("bne_taken", br(1'b1));
      applyStimulus(7'b1100011, 3'b001, 7'b0000000, 1, 0, 1);
      checkOutput("bne2_fetch", F1);
      checkOutput("bne2_decode", DEC);
      checkOutput("bne_not_taken", br(1'b0));
      applyStimulus(7'b1100011, 3'b100, 7'b0000000, 0, 1, 1);
      checkOutput("blt_fetch", F1);
      checkOutput("blt_decode", DEC);
      checkOutput("blt_taken", br(1'b1));
      applyStimulus(7'b1100011, 3'b101, 7'b0000000, 1, 1, 1);
      checkOutput("f3_101_fetch", F1);
      checkOutput("f3_101_decode", DEC);
      checkOutput("f3_101_not_taken", br(1'b0));
      applyStimulus(7'b1100011, 3'b000, 7'b0000000, 1, 0, 1);
      checkOutput("beq_fetch", F1);
      checkOutput("beq_decode", DEC);
      checkOutput("beq_taken", br(1'b1));
      applyStimulus(7'b1100011, 3'b100, 7'b0000000, 1, 0, 1);
      checkOutput("blt2_fetch", F1);
      checkOutput("blt2_decode", DEC);
      checkOutput("blt_not_taken", br(1'b0));

      $display("[TB] sw with memory waits");
      applyStimulus(7'b0100011, 3'b010, 7'b0000000, 0, 0, 1);
      checkOutput("sw_fetch", F1);
      checkOutput("sw_decode", DEC);
      checkOutput("sw_memadr", MASW);
      mem_ready = 1'b0;
      repeat (4) checkOutput("sw_memwrite_wait", MW0);
      mem_ready = 1'b1;
      checkOutput("sw_memwrite_done", MW1);

      $display("[TB] ALU decode variants");
      applyStimulus(7'b0110011, 3'b000, 7'b0100000, 0, 0, 1);
      checkOutput("sub_fetch_after_sw", F1);
      checkOutput("sub_decode", DEC);
      checkOutput("sub_execr", execR(3'b001));
      checkOutput("sub_aluwb", WB);
      applyStimulus(7'b0010011, 3'b000, 7'b0100000, 0, 0, 1);
      checkOutput("addi_fetch", F1);
      checkOutput("addi_decode", DEC);
      checkOutput("addi_execi", execI(3'b000));
      checkOutput("addi_aluwb", WB);
      applyStimulus(7'b0010011, 3'b110, 7'b0000000, 0, 0, 1);
      checkOutput("ori_fetch", F1);
      checkOutput("ori_decode", DEC);
      checkOutput("ori_execi", execI(3'b011));
      checkOutput("ori_aluwb", WB);
      applyStimulus(7'b0110011, 3'b010, 7'b0000000, 0, 0, 1);
      checkOutput("slt_fetch", F1);
      checkOutput("slt_decode", DEC);
      checkOutput("slt_execr", execR(3'b101));
      checkOutput("slt_aluwb", WB);
      applyStimulus(7'b0110011, 3'b111, 7'b0000000, 0, 0, 1);
      checkOutput("and_fetch", F1);
      checkOutput("and_decode", DEC);
      checkOutput("and_execr", execR(3'b010));
      checkOutput("and_aluwb", WB);

      $display("[TB] jal");
      applyStimulus(7'b1101111, 3'b000, 7'b0000000, 0, 0, 1);
      checkOutput("jal_fetch", F1);
      checkOutput("jal_decode", DEC);
      checkOutput("jal_jal", JALV);
      checkOutput("jal_aluwb", WB);

      $display("[TB] illegal opcode");
      applyStimulus(7'b1111111, 3'b000, 7'b0000000, 0, 0, 1);
      checkOutput("ill_fetch", F1);
      checkOutput("ill_decode", DILL);

      $display("[TB] reset during memwrite");
      applyStimulus(7'b0100011, 3'b010, 7'b0000000, 0, 0, 1);
      checkOutput("ill_next_fetch", F1);
      checkOutput("sw2_decode", DEC);
      checkOutput("sw2_memadr", MASW);
      mem_ready = 1'b0;
      @(negedge clk);
      compare("sw2_memwrite", MW0);
      rst_n = 1'b0;
      #1;
      compare("reset_in_memwrite", 19'h0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      mem_ready = 1'b1;
      checkOutput("fetch_after_reset", F1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle control sequencer for the RISC_32I datapath with a shared instruction/data memory. It steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and drives all datapath enables and mux selects. It adds a req/ready handshake so that memory may take a variable number of cycles. It replaces the single-cycle control path when the core is built multi-cycle.

Parameters:
OPC_W, 7, opcode field width
ST_W, 4, state register width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
op  in  7  IR[6:0], stable from DECODE onward
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]
Zero  in  1  ALUResult == 0
Sign_Flag  in  1  ALUResult[31]
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
MemWrite  out  1  write strobe, qualified by mem_req
AdrSrc  out  1  0: PC, 1: ALUOut as the memory address
IRWrite  out  1  latch fetched word into IR and OldPC
PCWrite  out  1  load PCNext into PC
RegWrite  out  1  register file WE3
ALUSrcA  out  2  00: PC, 01: OldPC, 10: RD1
ALUSrcB  out  2  00: RD2, 01: ImmExt, 10: const 4
ResultSrc  out  2  00: ALUOut, 01: Data reg, 10: ALUResult
ImmSrc  out  2  00: I, 01: S, 10: B, 11: J
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
illegal_instr  out  1  one-cycle pulse on an unsupported opcode
instr_retired  out  1  one-cycle pulse in each instruction's final state

Behaviour:
- Reset: while rst_n=0 at a clk edge, the state loads FETCH. All outputs are forced to 0 combinationally while rst_n=0. The first cycle after release is FETCH. Reset mid-access abandons the access with no write.
- Outputs are Moore from state. The exceptions are IRWrite, PCWrite and instr_retired, which are gated by mem_ready or branch resolution where stated.
- Supported opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, B 1100011, jal 1101111.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10. Stay while mem_ready=0. When mem_ready=1: IRWrite=1, PCWrite=1, then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add. This computes the branch target into ALUOut.
  - lw/sw -> MEMADR; R -> EXECR; I -> EXECI; B -> BRANCH; jal -> JAL.
  - Any other opcode -> FETCH with illegal_instr=1. PC has already advanced by 4.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ImmSrc = 00 for lw / 01 for sw, add. Then go to MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_req=1, AdrSrc=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_retired=1, then go to FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1, all held. When mem_ready=1: instr_retired=1, then go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct, then go to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALUOp=funct, then go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_retired=1, then go to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = beq & Zero | bne & ~Zero | blt & Sign_Flag, with beq=000, bne=001, blt=100.
  - Any other funct3 gives PCWrite=0, i.e. not taken.
  - instr_retired=1, then go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 (target from ALUOut). Then go to ALUWB, which writes OldPC+4 into rd.
- ALUOp decode:
  - funct3 000: sub if op[5] & funct7[5], else add.
  - funct3 010: slt. 110: or. 111: and.
  - Other funct3 values: add.
- mem_req never asserts outside FETCH, MEMREAD or MEMWRITE. mem_ready is ignored in all other states.
- Latency with zero-wait memory:
  - lw: 5 cycles.
  - sw, R, I-ALU, jal: 4 cycles.
  - B: 3 cycles.
  - Illegal opcode: 2 cycles.
  - Each memory wait cycle adds 1.

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode localparams;
  - state encodings: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL;
  - ALUControl codes;
  - ALUSrcA/B and ResultSrc select codes.
- One sub-module: the existing alu_dec instance, driven by op[5], funct3, funct7 and the FSM's ALUOp.

Test Plan:
- Reset held 3 cycles, then released with mem_ready=1 -> all outputs 0 during reset; mem_req=1 and AdrSrc=0 in the first cycle after release; IRWrite=PCWrite=1.
- add x3,x1,x2 (0x002081B3), zero-wait -> states FETCH, DECODE, EXECR, ALUWB; ALUControl=000 in EXECR; RegWrite=1 only in cycle 4; instr_retired pulses once.
- lw with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMREAD -> retires in 10 cycles; IRWrite is never asserted while mem_ready=0; MemWrite is never 1.
- bne taken with Zero=0 -> PCWrite=1 in BRANCH; same instruction with Zero=1 -> PCWrite=0; blt with Sign_Flag=1 -> PCWrite=1; funct3=101 -> PCWrite=0.
- sw with mem_ready=0 for 4 cycles -> MemWrite=mem_req=1 and AdrSrc=1 held for 5 cycles; then FETCH.
- Opcode 0x7F -> illegal_instr pulses in DECODE, next state FETCH, RegWrite/MemWrite stay 0. rst_n=0 during MEMWRITE -> MemWrite drops in the same cycle and FETCH follows.
